// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - sequential signed radix-2 Booth multiplier, one iteration per clock, go/done handshake.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand bypasses the iterations and finishes in one cycle.
module booth_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go,
   input  logic [WIDTH-1:0]     ain,
   input  logic [WIDTH-1:0]     pin,
   output logic                 done,
   output logic                 busy,
   output logic [2*WIDTH-1:0]   p
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH:0]     a_q, a_d;
   logic [WIDTH:0]     m_q, m_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               q1_q, q1_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH:0]     sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         p_q     <= p_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      p_d     = p_q;
      sum     = a_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               m_d     = {ain[WIDTH-1], ain};
               q_d     = pin;
               a_d     = '0;
               q1_d    = 1'b0;
               cnt_d   = CW'(WIDTH);
               busy_d  = 1'b1;
               done_d  = 1'b0;
               state_d = CALC;
`ifdef BOOTH_ZERO_SKIP_EN
               if (ain == '0 || pin == '0) begin
                  q_d     = '0;
                  state_d = FIN;
               end
`endif
            end
         end
         CALC: begin
            case ({q_q[0], q1_q})
               2'b01:   sum = a_q + m_q;
               2'b10:   sum = a_q - m_q;
               default: sum = a_q;
            endcase
            // arithmetic shift of {A,Q,q_1}; A's extra bit keeps -2^(WIDTH-1) operands exact
            a_d   = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FIN;
               busy_d  = 1'b0;
            end
         end
         FIN: begin
            p_d     = {a_q[WIDTH-1:0], q_q};
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign done = done_q;
   assign busy = busy_q;
   assign p    = p_q;

endmodule

// File: doc/booth_mult.md
Name: booth_mult

Overview:
- Sequential signed radix-2 Booth multiplier: 8-bit two's-complement ain × pin produces a 16-bit two's-complement p.
- Sits directly upstream of the BCD/seven-segment display stage. That stage consumes p and treats p[15] as the sign digit.
- Started by a go/done handshake; one Booth iteration per clock.

Parameters:
- WIDTH, 8, operand width in bits; p is 2*WIDTH bits; iteration count = WIDTH

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- go  input  1  start request, sampled on rising clk
- ain  input  WIDTH  multiplicand, signed
- pin  input  WIDTH  multiplier, signed
- done  output  1  result valid, level
- busy  output  1  high while computing
- p  output  2*WIDTH  signed product, registered

Behaviour:
- Reset (rst_n low, async): state=IDLE, done=0, busy=0, p=0, all internal registers 0. Applies immediately, including mid-operation; the in-flight operation is discarded and no partial result reaches p.
- States: IDLE, CALC, FIN.
- IDLE:
  - go=1 on an edge → latch M=ain sign-extended to WIDTH+1 bits; Q=pin; A=0 (WIDTH+1 bits); q_1=0; cnt=WIDTH; busy=1; go to CALC.
- CALC, one iteration per cycle:
  - {Q[0],q_1}=01 → A=A+M; 10 → A=A−M; 00/11 → A unchanged.
  - Then arithmetic shift right of {A,Q,q_1} by 1, with A[WIDTH] replicated. cnt decrements.
  - After the cycle where cnt reaches 0 → go to FIN.
  - A is WIDTH+1 bits so ain=−2^(WIDTH−1) does not overflow.
- FIN (one cycle): p={A[WIDTH−1:0],Q}; done=1; busy=0; go to IDLE.
- Latency: go sampled at edge k → done=1 and p valid after edge k+WIDTH+1 (edge k+9 for WIDTH=8).
- done and p hold until the next accepted go. On that go edge, done clears; p holds its old value until the new result loads.
- go while busy=1 is ignored (no restart, no queuing). ain/pin are only sampled on the accepting edge, so changes during CALC have no effect.
- go held high continuously gives back-to-back operations: new acceptance on the edge after done rises.
- Full range is exact; no overflow case: (−128)×(−128)=+16384 fits in 16 bits signed.

Optional Feature:
- Macro BOOTH_ZERO_SKIP_EN.
- Defined: in IDLE, if go=1 and (ain==0 or pin==0), skip CALC. Go directly to FIN: p=0, done=1 after edge k+1, busy=1 for that single cycle.
- Undefined: zero operands take the full WIDTH+1 cycle latency. The result is identical (p=0).

Test Plan:
- go, ain=3, pin=5 → done rises after 9th edge; p=0x000F; busy high for exactly 8 cycles.
- ain=−128 (0x80), pin=−128 → p=0x4000; ain=−128, pin=127 → p=0xC080; ain=127, pin=−1 → p=0xFF81.
- Start ain=10, pin=10, pulse go again at cycle 4 with ain=2, pin=2 → second go ignored; p=0x0064 at cycle 9.
- Hold go=1 continuously with ain=−7, pin=6 → repeated results p=0xFFD6, done pulses once per operation with one IDLE cycle between; verify back-to-back spacing.
- Assert rst_n low at cycle 5 of an operation → done=0, busy=0, p=0 immediately (asynchronously). After release, a new go with 2×3 gives p=0x0006 at normal latency.
- ain=0, pin=−77: with BOOTH_ZERO_SKIP_EN, done after edge k+1, p=0; without it, done after edge k+9, p=0.
